// File: rtl/random_cell_picker_pkg.sv
// Shared types and constants for the random free-cell picker.
package random_cell_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/random_cell_picker_if.sv
// Request/result bundle between the board logic (master) and the picker (slave).
interface random_cell_picker_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int LFSR_W = 16
);
    localparam int N  = ROWS * COLS;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Handshake: req is taken only while the picker is idle (busy=0, done=0);
    // it is never queued. done is a one-cycle strobe, and found/rx/ry are valid
    // from that strobe until the next one.
    logic [N-1:0]      occupied;
    logic              req;
    logic              mode_seq;
    logic              seed_we;
    logic [LFSR_W-1:0] seed;
    logic              busy;
    logic              done;
    logic              found;
    logic [CW-1:0]     rx;
    logic [RW-1:0]     ry;

    modport master (output occupied, req, mode_seq, seed_we, seed,
                    input  busy, done, found, rx, ry);
    modport slave  (input  occupied, req, mode_seq, seed_we, seed,
                    output busy, done, found, rx, ry);
endinterface

// File: rtl/random_cell_picker_lfsr16.sv
// 16-bit Galois LFSR, free-running, with a synchronous load that never loads zero.
module lfsr16
    import random_cell_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] value
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (load) begin
            // An all-zero state would lock the LFSR, so fall back to the seed.
            value <= (load_val == 16'h0) ? SEED : load_val;
        end else begin
            value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0);
        end
    end
endmodule

// File: rtl/random_cell_picker.sv
// Picks a pseudo-random (or first-fit) free cell from a snapshot of the board occupancy map.
module random_cell_picker
    import random_cell_pkg::*;
#(
    parameter int          ROWS   = 4,
    parameter int          COLS   = 4,
    parameter int          LFSR_W = 16,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    random_cell_picker_if.slave  bus,
    output state_t               dbg_state
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t            state, state_nx;
    logic [LFSR_W-1:0] lfsr;
    logic [N-1:0]      snap;
    logic [IW-1:0]     idx, cnt, start_idx;
    logic              found_r;
    logic [CW-1:0]     rx_r;
    logic [RW-1:0]     ry_r;
    logic              hit, last;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.seed_we),
        .load_val (bus.seed[15:0]),
        .value    (lfsr)
    );

    assign start_idx = bus.mode_seq ? '0 : IW'(lfsr % N);
    assign hit       = ~snap[idx];
    assign last      = (cnt == IW'(N - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req) state_nx = SCAN;
            SCAN:    if (hit || last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            snap    <= '0;
            idx     <= '0;
            cnt     <= '0;
            found_r <= 1'b0;
            rx_r    <= '0;
            ry_r    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        snap <= bus.occupied;
                        idx  <= start_idx;
                        cnt  <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        // Constant divisor: a bit slice when COLS is a power of two.
                        found_r <= 1'b1;
                        rx_r    <= CW'(idx % COLS);
                        ry_r    <= RW'(idx / COLS);
                    end else if (last) begin
                        found_r <= 1'b0;
                        rx_r    <= '0;
                        ry_r    <= '0;
                    end else begin
                        idx <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
                        cnt <= cnt + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == SCAN);
    assign bus.done  = (state == DONE);
    assign bus.found = found_r;
    assign bus.rx    = rx_r;
    assign bus.ry    = ry_r;
    assign dbg_state = state;
endmodule
